// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP32 add/sub unit
// among NREQ requesters, with a tag pipeline that routes results back.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   req_valid/ready   per-requester handshake; ready is a one-hot grant
//   req_a, req_b      packed FP32 operands, requester i at [32*i +: 32]
//   req_sub           per-requester op select (1 = A-B)
//   fu_a/b/sub/valid  registered issue to the shared unit
//   fu_result         unit result, valid LAT cycles after fu_valid
//   res_data/valid    registered result, one-hot strobe to requester
//   inflight          issued operations not yet returned
module fp32_add_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [32*NREQ-1:0]         req_a,
  input  logic [32*NREQ-1:0]         req_b,
  input  logic [NREQ-1:0]            req_sub,
  output logic [NREQ-1:0]            req_ready,
  output logic [31:0]                fu_a,
  output logic [31:0]                fu_b,
  output logic                       fu_sub,
  output logic                       fu_valid,
  input  logic [31:0]                fu_result,
  output logic [31:0]                res_data,
  output logic [NREQ-1:0]            res_valid,
  output logic [$clog2(LAT+2)-1:0]   inflight
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LAT+2);

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [31:0]     fa_q, fa_d;
  logic [31:0]     fb_q, fb_d;
  logic            fs_q, fs_d;
  logic            fv_q, fv_d;
  logic [LAT:0]    tv_q, tv_d;
  logic [IW-1:0]   ti_q [LAT+1];
  logic [IW-1:0]   ti_d [LAT+1];
  logic [31:0]     rd_q, rd_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic [CW-1:0]   inf_q, inf_d;

  logic            found;
  logic [IW-1:0]   gidx;
  logic            acc;
  logic            ret;

  // First valid requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int s;
      s = int'(ptr_q) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!found && req_valid[s]) begin
        found = 1'b1;
        gidx  = IW'(s);
      end
    end
  end

  assign acc       = found && !rst;
  assign ret       = tv_q[LAT];
  assign req_ready = acc ? (NREQ'(1) << gidx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    fa_d  = fa_q;
    fb_d  = fb_q;
    fs_d  = fs_q;
    fv_d  = acc;
    if (acc) begin
      ptr_d = (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
      fa_d  = req_a[32*gidx +: 32];
      fb_d  = req_b[32*gidx +: 32];
      fs_d  = req_sub[gidx];
    end

    // Tag stage 0 is loaded on the same edge as fu_valid, so the
    // final stage lines up with the cycle fu_result is valid.
    tv_d     = {tv_q[LAT-1:0], acc};
    ti_d[0]  = gidx;
    for (int k = 1; k <= LAT; k++) begin
      ti_d[k] = ti_q[k-1];
    end

    rv_d = '0;
    rd_d = rd_q;
    if (ret) begin
      rv_d = NREQ'(1) << ti_q[LAT];
      rd_d = fu_result;
    end

    inf_d = inf_q;
    unique case ({acc, ret})
      2'b10:   inf_d = inf_q + CW'(1);
      2'b01:   inf_d = inf_q - CW'(1);
      default: inf_d = inf_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      fa_q  <= '0;
      fb_q  <= '0;
      fs_q  <= 1'b0;
      fv_q  <= 1'b0;
      tv_q  <= '0;
      for (int k = 0; k <= LAT; k++) begin
        ti_q[k] <= '0;
      end
      rd_q  <= '0;
      rv_q  <= '0;
      inf_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      fa_q  <= fa_d;
      fb_q  <= fb_d;
      fs_q  <= fs_d;
      fv_q  <= fv_d;
      tv_q  <= tv_d;
      for (int k = 0; k <= LAT; k++) begin
        ti_q[k] <= ti_d[k];
      end
      rd_q  <= rd_d;
      rv_q  <= rv_d;
      inf_q <= inf_d;
    end
  end

  assign fu_a      = fa_q;
  assign fu_b      = fb_q;
  assign fu_sub    = fs_q;
  assign fu_valid  = fv_q;
  assign res_data  = rd_q;
  assign res_valid = rv_q;
  assign inflight  = inf_q;

endmodule
